// File: rtl/magic_pkt_driver_pkg.sv
// Shared types for the magic packet driver: FSM state encoding and LFSR tap masks.
// Tap masks are for a right-shifting Galois LFSR; unlisted widths fall back to a simple rotate.
package magic_pkt_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_MAGIC = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [31:0] LFSR_SEED = 32'd1;

    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            2:       taps = 32'h0000_0003;
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            16:      taps = 32'h0000_B400;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h1 << (width - 1);
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/magic_pkt_driver_pkt_lfsr.sv
// Filler-data generator: Galois LFSR, seeded to 1 on reset, steps once per adv.
// Latency: value reflects the current state; a step is visible the cycle after adv.
// Backpressure: none, the owner only raises adv for accepted filler pushes.
module pkt_lfsr
    import magic_pkt_driver_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SEED = WIDTH'(LFSR_SEED);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) begin
            lfsr_d = {1'b0, lfsr_q[WIDTH-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/magic_pkt_driver.sv
// FIFO exerciser: pushes N LFSR fillers then one magic word (flagged by start), then drains.
// Latency: first push the cycle after go; done one cycle after the pop that empties the FIFO.
// Backpressure: push gated by full, pop gated by empty, both combinationally; counts never slip.
`ifndef FIFO_DWIDTH
`define FIFO_DWIDTH 8
`endif
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 8
`endif

module magic_pkt_driver
    import magic_pkt_driver_pkg::*;
#(
    parameter  int WIDTH  = `FIFO_DWIDTH,
    parameter  int DEPTH  = `FIFO_DEPTH,
    parameter  int PWID   = 8,
    localparam int CNTWID = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [PWID-1:0]   pre_count,
    input  logic [WIDTH-1:0]  magic_data,
    input  logic              full,
    input  logic              empty,
    output logic              push,
    output logic              pop,
    output logic              start,
    output logic [WIDTH-1:0]  data_out,
    output logic              busy,
    output logic              done,
    output logic [CNTWID-1:0] occ
);

    localparam logic [CNTWID-1:0] OCC_MAX = CNTWID'(DEPTH);
    localparam logic [WIDTH-1:0]  LSB_ONE = WIDTH'(1);

    state_e            state_q, state_d;
    logic [PWID-1:0]   fill_cnt_q, fill_cnt_d;
    logic [WIDTH-1:0]  magic_q, magic_d;
    logic [CNTWID-1:0] occ_q, occ_d;
    logic              tog_q, tog_d;

    logic              lfsr_adv;
    logic [WIDTH-1:0]  lfsr_val;
    logic [WIDTH-1:0]  filler;

    pkt_lfsr #(
        .WIDTH (WIDTH)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .adv   (lfsr_adv),
        .value (lfsr_val)
    );

    // A filler that collides with the magic word would fake an early match downstream.
    assign filler = (lfsr_val == magic_q) ? (lfsr_val ^ LSB_ONE) : lfsr_val;

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        magic_d    = magic_q;
        tog_d      = ~tog_q;
        push       = 1'b0;
        pop        = 1'b0;
        start      = 1'b0;
        done       = 1'b0;
        data_out   = '0;
        lfsr_adv   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    fill_cnt_d = pre_count;
                    magic_d    = magic_data;
                    state_d    = (pre_count != '0) ? ST_FILL : ST_MAGIC;
                end
            end
            ST_FILL: begin
                data_out = filler;
                push     = ~full;
                pop      = tog_q & ~empty;
                if (push) begin
                    lfsr_adv   = 1'b1;
                    fill_cnt_d = fill_cnt_q - PWID'(1);
                    if (fill_cnt_q == PWID'(1)) begin
                        state_d = ST_MAGIC;
                    end
                end
            end
            ST_MAGIC: begin
                data_out = magic_q;
                push     = ~full;
                start    = push;
                pop      = tog_q & ~empty;
                if (push) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                pop = ~empty;
                if ((occ_q == CNTWID'(1) && pop) || occ_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = (occ_q == OCC_MAX) ? occ_q : occ_q + CNTWID'(1);
        end else if (pop && !push) begin
            occ_d = (occ_q == '0) ? occ_q : occ_q - CNTWID'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fill_cnt_q <= '0;
            magic_q    <= '0;
            occ_q      <= '0;
            tog_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            magic_q    <= magic_d;
            occ_q      <= occ_d;
            tog_q      <= tog_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign occ  = occ_q;

endmodule

// File: tb/tb_magic_pkt_driver.sv
// Randomized bench: a queue-based FIFO model plus per-run expected push lists checks the driver.
module tb_magic_pkt_driver;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int PW = 8;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          go = 1'b0;
    logic [PW-1:0] pre_count = '0;
    logic [W-1:0]  magic_data = '0;
    logic          full = 1'b0;
    logic          empty = 1'b1;
    logic          push, pop, start, busy, done;
    logic [W-1:0]  data_out;
    logic [CW-1:0] occ;

    always #5 clk = ~clk;

    magic_pkt_driver #(
        .WIDTH (W),
        .DEPTH (D),
        .PWID  (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .pre_count  (pre_count),
        .magic_data (magic_data),
        .full       (full),
        .empty      (empty),
        .push       (push),
        .pop        (pop),
        .start      (start),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .occ        (occ)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         st;
    } exp_t;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [W-1:0] fq[$];
    logic [W-1:0] popped[$];
    exp_t         expq[$];
    logic [W-1:0] mlfsr = 8'h01;
    logic [W-1:0] magic_lat = '0;
    bit           force_full = 1'b0;
    bit           force_empty = 1'b0;
    int           cyc = 0;
    int           last_pop_cyc = -1;
    int           done_cyc = -1;
    int           first_push_cyc = -1;
    int           n_push = 0;
    int           n_start = 0;

    // x^8 + x^6 + x^5 + x^4 + 1 stepped as polynomial multiplication by x^-1
    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
        logic [W-1:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 8'hB8;
        return r;
    endfunction

    task automatic upd_flags();
        full  = force_full  || (fq.size() >= D);
        empty = force_empty || (fq.size() == 0);
    endtask

    // Observe one cycle at the falling edge, apply its FIFO effect, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("occ_tracks_fifo", occ, fq.size());
        if (push) begin
            n_push++;
            if (first_push_cyc < 0) first_push_cyc = cyc;
            chk("push_while_full", full, 0);
            chk("push_expected", expq.size() != 0, 1);
            if (expq.size() != 0) begin
                chk("push_data", data_out, expq[0].d);
                chk("push_start", start, expq[0].st);
                if (!expq[0].st) chk("filler_ne_magic", data_out != magic_lat, 1);
                void'(expq.pop_front());
            end
            if (start) n_start++;
        end else begin
            chk("start_without_push", start, 0);
        end
        if (pop) begin
            chk("pop_while_empty", empty, 0);
            if (fq.size() != 0) popped.push_back(fq.pop_front());
            last_pop_cyc = cyc;
        end
        if (push) fq.push_back(data_out);
        if (done) begin
            done_cyc = cyc;
            chk("done_after_last_pop", cyc, last_pop_cyc + 1);
            chk("busy_in_done", busy, 1);
        end
        @(posedge clk);
        #1;
        upd_flags();
    endtask

    task automatic build_expect(input int pc, input logic [W-1:0] mg);
        exp_t e;
        magic_lat = mg;
        for (int i = 0; i < pc; i++) begin
            e.d  = (mlfsr == mg) ? (mlfsr ^ 8'h01) : mlfsr;
            e.st = 1'b0;
            expq.push_back(e);
            mlfsr = lfsr_next(mlfsr);
        end
        e.d  = mg;
        e.st = 1'b1;
        expq.push_back(e);
    endtask

    task automatic run(input int pc, input logic [W-1:0] mg, input bit hold, input int full_at);
        int go_cyc;
        build_expect(pc, mg);
        popped.delete();
        n_push = 0;
        n_start = 0;
        done_cyc = -1;
        last_pop_cyc = -1;
        first_push_cyc = -1;
        pre_count  = PW'(pc);
        magic_data = mg;
        go = 1'b1;
        tick();
        go_cyc = cyc;
        chk("busy_after_go", busy, 1);
        if (!hold) begin
            go = 1'b0;
            pre_count  = PW'($urandom);
            magic_data = W'($urandom);
        end
        for (int t = 0; t < 600 && done_cyc < 0; t++) begin
            force_full = (full_at >= 0) && (t >= full_at) && (t < full_at + 5);
            upd_flags();
            tick();
        end
        force_full = 1'b0;
        go = 1'b0;
        upd_flags();
        chk("run_completes", done_cyc >= 0, 1);
        chk("idle_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("push_count", n_push, pc + 1);
        chk("start_count", n_start, 1);
        chk("expected_all_pushed", expq.size(), 0);
        chk("pop_count", popped.size(), pc + 1);
        chk("magic_position", (popped.size() > pc) ? popped[pc] : ~mg, mg);
        chk("fifo_drained", fq.size(), 0);
        if (full_at != 0) chk("first_push_latency", first_push_cyc, go_cyc + 1);
        expq.delete();
    endtask

    initial begin
        int pc;
        logic [W-1:0] mg;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_push", push, 0);
        chk("rst_pop", pop, 0);
        chk("rst_start", start, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_occ", occ, 0);
        chk("rst_data_out", data_out, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run(0, 8'h0B, 1'b0, -1);
        run(3, W'($urandom), 1'b0, -1);
        run(20, W'($urandom), 1'b0, 3);
        mg = mlfsr;
        run(2, mg, 1'b0, -1);
        run(5, W'($urandom), 1'b1, -1);
        for (int k = 0; k < 8; k++) begin
            pc = $urandom_range(0, 12);
            run(pc, W'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : -1);
        end

        // Abort in DRAIN with three words stranded behind a forced-empty FIFO.
        force_empty = 1'b1;
        upd_flags();
        build_expect(2, W'($urandom));
        n_start = 0;
        pre_count = PW'(2);
        magic_data = magic_lat;
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int t = 0; t < 50 && n_start == 0; t++) tick();
        chk("abort_reached_drain", n_start, 1);
        tick();
        tick();
        chk("abort_occ_before", occ, 3);
        chk("abort_busy_before", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_push", push, 0);
        chk("abort_pop", pop, 0);
        chk("abort_busy", busy, 0);
        chk("abort_occ", occ, 0);
        chk("abort_done", done, 0);
        fq.delete();
        expq.delete();
        mlfsr = 8'h01;
        force_empty = 1'b0;
        upd_flags();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("idle_after_abort", busy, 0);
            chk("no_done_after_abort", done, 0);
        end
        run(4, W'($urandom), 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/magic_pkt_driver.md
MAGIC_PKT_DRIVER -- requirements
Module: magic_pkt_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default `FIFO_DWIDTH, meaning the data word width.
REQ-002 The block SHALL have parameter DEPTH, default `FIFO_DEPTH, meaning the capacity of the FIFO under test.
REQ-003 The block SHALL have parameter PWID, default 8, meaning the width of the filler-count input.
REQ-004 The block SHALL have localparam CNTWID = $clog2(DEPTH)+1, meaning the occupancy counter width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port go, input, 1 bit: starts a run; sampled in IDLE only.
REQ-008 The block SHALL have port pre_count, input, PWID bits: number of filler packets before the magic packet; latched on go.
REQ-009 The block SHALL have port magic_data, input, WIDTH bits: magic packet value; latched on go.
REQ-010 The block SHALL have ports full and empty, input, 1 bit each: FIFO status.
REQ-011 The block SHALL have ports push, pop and start, output, 1 bit each: FIFO and scoreboard stimulus.
REQ-012 The block SHALL have port data_out, output, WIDTH bits: push data.
REQ-013 The block SHALL have ports busy and done, output, 1 bit each: busy is high outside IDLE; done is a one-cycle pulse at run end.
REQ-014 The block SHALL have port occ, output, CNTWID bits: driver-tracked FIFO occupancy.

Function
REQ-015 The FSM SHALL have the states IDLE, FILL, MAGIC, DRAIN and DONE.
REQ-016 IDLE -> FILL on go when pre_count != 0; IDLE -> MAGIC on go when pre_count == 0; go outside IDLE is ignored.
REQ-017 FILL SHALL push filler words; a filler counter SHALL decrement per accepted push; the last filler push -> MAGIC.
REQ-018 MAGIC SHALL push magic_data with start=1 in the same cycle; start SHALL be asserted only then, exactly once per run; accepted push -> DRAIN.
REQ-019 DRAIN SHALL assert pop every cycle that empty=0; when occ==1 and pop is asserted, or occ==0 -> DONE.
REQ-020 DONE SHALL assert done for one cycle, then -> IDLE.
REQ-021 push SHALL be asserted only when full=0, combinationally gated; data_out SHALL be valid whenever push=1.
REQ-022 pop SHALL be asserted only when empty=0, combinationally gated.
REQ-023 In FILL and MAGIC, pop SHALL follow a toggle bit flipped every cycle, so that simultaneous push+pop occurs.
REQ-024 Filler data SHALL come from a WIDTH-bit maximal LFSR that advances on each filler push; if the LFSR value equals the latched magic value, data_out SHALL be that value XOR 1, so filler never equals magic.
REQ-025 occ SHALL update +1 on push only, -1 on pop only, and be unchanged on both or neither; it SHALL saturate at DEPTH and 0 (never wraps).
REQ-026 With pre_count >= DEPTH, FILL SHALL stall on full without losing count; the run SHALL still complete.

Reset
REQ-027 On rst=0, the FSM SHALL go to IDLE asynchronously, and push, pop, start, done and busy SHALL be 0.
REQ-028 On rst=0, occ and the filler counter SHALL be 0, the latched magic and data_out SHALL be 0, the toggle bit SHALL be 0, and the LFSR SHALL be a nonzero seed of 1.
REQ-029 Reset mid-run SHALL abort with no done pulse; after deassertion the block SHALL idle until the next go.

Structure
REQ-030 The state enum and LFSR tap constants per WIDTH SHALL reside in the shared package; WIDTH and DEPTH defaults come from options.v.
REQ-031 One sub-module, pkt_lfsr (advance enable, seed on reset), SHALL be used; the remaining logic stays flat.

Verification
REQ-032 pre_count=0, magic=0xB: push with start=1 in the cycle after go; single pop on the next non-empty cycle; done 1 cycle later; occ returns to 0.
REQ-033 pre_count=3, DEPTH=8, connected to fifo plus Scoreboard: magic exits fourth; prop_signal stays 1 throughout.
REQ-034 pre_count=20, DEPTH=4, with full forced high for 5 cycles: no push while full; exactly 20 filler pushes and 1 magic push, then done.
REQ-035 LFSR forced to equal magic=0x5: the emitted filler is 0x4, never 0x5.
REQ-036 rst pulled low during DRAIN with occ=3: push, pop and busy go to 0 immediately; no done; a new go completes normally.
REQ-037 go held high during a run: no restart, start asserted once; a pop pulse occurs when the toggle is high and empty=0.
